// File: rtl/cache_pkg.sv
// Shared cache package: victim-cache FSM state encoding and the entry and
// interface bundles that sit next to the write-back dcache port types.
// The bundle widths match the default 32-bit address / 128-bit line
// configuration used by the dcache.
package cache_pkg;

  localparam int VC_ADDR_W = 32;
  localparam int VC_LINE_W = 128;
  localparam int VC_OFF_W  = $clog2(VC_LINE_W / 8);
  localparam int VC_TAG_W  = VC_ADDR_W - VC_OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    RESP,
    WB_EVICT,
    FLUSH_SCAN,
    FLUSH_WB,
    DONE
  } type_vc_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [VC_TAG_W-1:0]  tag;
    logic [VC_LINE_W-1:0] line;
  } type_vc_entry_s;

  typedef struct packed {
    logic                 req;
    logic [VC_ADDR_W-1:0] addr;
  } type_vc_lookup_req_s;

  typedef struct packed {
    logic                 ack;
    logic                 hit;
    logic [VC_LINE_W-1:0] line;
    logic                 dirty;
  } type_vc_lookup_rsp_s;

  typedef struct packed {
    logic                 req;
    logic [VC_ADDR_W-1:0] addr;
    logic [VC_LINE_W-1:0] line;
    logic                 dirty;
  } type_vc_evict_req_s;

  typedef struct packed {
    logic                 req;
    logic                 w_en;
    logic [VC_ADDR_W-1:0] addr;
    logic [VC_LINE_W-1:0] w_data;
  } type_vc_mem_req_s;

endpackage

// File: rtl/victim_cache_ctrl_repl.sv
// victim_repl_sel: replacement state and victim index for the victim cache.
//   clk, rst    : clock, asynchronous active-high reset
//   valid_i     : entry valid vector as seen by the current insert
//   upd_i       : an entry is written this cycle (insert)
//   upd_idx_i   : index of the written entry
//   repl_i      : the write displaced the victim of a full array
//   victim_o    : index to displace when the array is full
// REPL_MODE 0 = round-robin FIFO pointer, 1 = LRU age counters.
module victim_repl_sel #(
  parameter int NUM_ENTRIES = 4,
  parameter int REPL_MODE   = 0,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ENTRIES-1:0] valid_i,
  input  logic                   upd_i,
  input  logic [IDX_W-1:0]       upd_idx_i,
  input  logic                   repl_i,
  output logic [IDX_W-1:0]       victim_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] age_q [NUM_ENTRIES];
  logic [IDX_W-1:0] age_d [NUM_ENTRIES];
  logic [IDX_W-1:0] old_age;
  logic [IDX_W-1:0] lru_idx;
  logic [IDX_W-1:0] lru_age;

  // An empty slot counts as the oldest, so every valid entry ages by one.
  always_comb begin
    old_age = valid_i[upd_idx_i] ? age_q[upd_idx_i] : '1;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      age_d[i] = age_q[i];
      if (upd_i) begin
        if (upd_idx_i == IDX_W'(i)) begin
          age_d[i] = '0;
        end else if (valid_i[i] && (age_q[i] < old_age)) begin
          age_d[i] = age_q[i] + IDX_W'(1);
        end
      end
    end
  end

  // Oldest entry wins; the lowest index breaks ties.
  always_comb begin
    lru_idx = '0;
    lru_age = age_q[0];
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      if (age_q[i] > lru_age) begin
        lru_idx = IDX_W'(i);
        lru_age = age_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= '0;
    end else begin
      if (upd_i && repl_i) ptr_q <= ptr_q + IDX_W'(1);
      for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= age_d[i];
    end
  end

  assign victim_o = (REPL_MODE == 1) ? lru_idx : ptr_q;

endmodule

// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl: fully associative victim cache between the write-back
// dcache and memory. Holds dcache evictions, hands them back exclusively on a
// later dcache miss, and writes dirty lines back on displacement or flush.
//   lookup_*  : dcache miss probe, answered one cycle after the request
//   evict_*   : dcache eviction insert, acknowledged when the line is stored
//   mem_*     : write-back port, request held until mem_ack_i
//   flush_i / flush_done_o : write back dirty lines, then invalidate all
//   occupancy_o : registered count of valid entries
module victim_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int NUM_ENTRIES = 4,
  parameter int REPL_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lookup_req_i,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr_i,
  output logic                         lookup_ack_o,
  output logic                         lookup_hit_o,
  output logic [LINE_WIDTH-1:0]        lookup_line_o,
  output logic                         lookup_dirty_o,
  input  logic                         evict_req_i,
  input  logic [ADDR_WIDTH-1:0]        evict_addr_i,
  input  logic [LINE_WIDTH-1:0]        evict_line_i,
  input  logic                         evict_dirty_i,
  output logic                         evict_ack_o,
  output logic                         mem_req_o,
  output logic                         mem_w_en_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [LINE_WIDTH-1:0]        mem_w_data_o,
  input  logic                         mem_ack_i,
  input  logic                         flush_i,
  output logic                         flush_done_o,
  output logic [$clog2(NUM_ENTRIES):0] occupancy_o
);

  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int TAG_W = ADDR_WIDTH - OFF_W;
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  type_vc_state_e state_q, state_d;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [NUM_ENTRIES-1:0] valid_eff, dirty_eff, lk_hit_vec, ev_hit_vec;
  logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
  logic [LINE_WIDTH-1:0]  line_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       lk_tag, ev_tag;
  logic [IDX_W-1:0]       lk_idx, ev_idx, free_idx, victim_idx;
  logic [IDX_W-1:0]       scan_idx_q, scan_idx_d, pend_idx_q, pend_idx_d;
  logic [IDX_W-1:0]       resp_idx_q, resp_idx_d, wr_idx, wb_idx;
  logic                   resp_hit_q, resp_hit_d, resp_dirty_q;
  logic [LINE_WIDTH-1:0]  resp_line_q;
  logic [ADDR_WIDTH-1:0]  wb_addr_q;
  logic [LINE_WIDTH-1:0]  wb_data_q;
  logic                   evict_ack_q, evict_ack_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   lk_load, wb_load, wr_en, wr_dirty, ev_go, repl_repl;
  logic                   unused_addr_bits;

  assign lk_tag = lookup_addr_i[ADDR_WIDTH-1:OFF_W];
  assign ev_tag = evict_addr_i[ADDR_WIDTH-1:OFF_W];
  assign unused_addr_bits = ^{lookup_addr_i[OFF_W-1:0], evict_addr_i[OFF_W-1:0]};

  // The entry handed back in RESP is already gone for an insert in the same
  // cycle, which lets a swap reuse the slot it just freed.
  always_comb begin
    valid_eff = valid_q;
    dirty_eff = dirty_q;
    if (state_q == RESP && resp_hit_q) begin
      valid_eff[resp_idx_q] = 1'b0;
      dirty_eff[resp_idx_q] = 1'b0;
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      lk_hit_vec[i] = valid_q[i] && (tag_q[i] == lk_tag);
      ev_hit_vec[i] = valid_eff[i] && (tag_q[i] == ev_tag);
    end
  end

  always_comb begin
    lk_idx   = '0;
    ev_idx   = '0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (lk_hit_vec[i]) lk_idx   = IDX_W'(i);
      if (ev_hit_vec[i]) ev_idx   = IDX_W'(i);
      if (!valid_eff[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_eff;
    dirty_d     = dirty_eff;
    scan_idx_d  = scan_idx_q;
    pend_idx_d  = pend_idx_q;
    resp_idx_d  = resp_idx_q;
    resp_hit_d  = resp_hit_q;
    evict_ack_d = 1'b0;
    lk_load     = 1'b0;
    wb_load     = 1'b0;
    wb_idx      = '0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_dirty    = 1'b0;
    repl_repl   = 1'b0;
    ev_go       = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_i) begin
          scan_idx_d = '0;
          state_d    = FLUSH_SCAN;
        end else if (lookup_req_i) begin
          lk_load    = 1'b1;
          resp_hit_d = |lk_hit_vec;
          resp_idx_d = lk_idx;
          state_d    = RESP;
        end else if (evict_req_i && !evict_ack_q) begin
          // evict_ack_q blocks the still-held request of the insert just done
          ev_go = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (evict_req_i && !evict_ack_q) ev_go = 1'b1;
      end
      WB_EVICT: begin
        if (mem_ack_i) begin
          wr_en     = 1'b1;
          wr_idx    = pend_idx_q;
          wr_dirty  = evict_dirty_i;
          repl_repl = 1'b1;
          state_d   = IDLE;
        end
      end
      FLUSH_SCAN: begin
        if (valid_q[scan_idx_q] && dirty_q[scan_idx_q]) begin
          wb_load = 1'b1;
          wb_idx  = scan_idx_q;
          state_d = FLUSH_WB;
        end else if (scan_idx_q == LAST_IDX) begin
          valid_d = '0;
          dirty_d = '0;
          state_d = DONE;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      FLUSH_WB: begin
        if (mem_ack_i) begin
          dirty_d[scan_idx_q] = 1'b0;
          if (scan_idx_q == LAST_IDX) begin
            valid_d = '0;
            dirty_d = '0;
            state_d = DONE;
          end else begin
            scan_idx_d = scan_idx_q + IDX_W'(1);
            state_d    = FLUSH_SCAN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ev_go) begin
      if (|ev_hit_vec) begin
        wr_en    = 1'b1;
        wr_idx   = ev_idx;
        wr_dirty = dirty_eff[ev_idx] | evict_dirty_i;
      end else if (!(&valid_eff)) begin
        wr_en    = 1'b1;
        wr_idx   = free_idx;
        wr_dirty = evict_dirty_i;
      end else if (dirty_eff[victim_idx]) begin
        // Dirty victim: write it back first, install on mem_ack_i.
        wb_load    = 1'b1;
        wb_idx     = victim_idx;
        pend_idx_d = victim_idx;
        state_d    = WB_EVICT;
      end else begin
        wr_en     = 1'b1;
        wr_idx    = victim_idx;
        wr_dirty  = evict_dirty_i;
        repl_repl = 1'b1;
      end
    end

    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      dirty_d[wr_idx] = wr_dirty;
      evict_ack_d     = 1'b1;
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) occ_d = occ_d + OCC_W'(valid_d[i]);
  end

  victim_repl_sel #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .REPL_MODE   (REPL_MODE)
  ) u_repl (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_eff),
    .upd_i     (wr_en),
    .upd_idx_i (wr_idx),
    .repl_i    (repl_repl),
    .victim_o  (victim_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      scan_idx_q  <= '0;
      pend_idx_q  <= '0;
      resp_idx_q  <= '0;
      resp_hit_q  <= 1'b0;
      evict_ack_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      scan_idx_q  <= scan_idx_d;
      pend_idx_q  <= pend_idx_d;
      resp_idx_q  <= resp_idx_d;
      resp_hit_q  <= resp_hit_d;
      evict_ack_q <= evict_ack_d;
      occ_q       <= occ_d;
    end
  end

  // Payload registers carry no reset; valid bits and output gating cover them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= ev_tag;
      line_q[wr_idx] <= evict_line_i;
    end
    if (lk_load) begin
      resp_line_q  <= line_q[lk_idx];
      resp_dirty_q <= dirty_q[lk_idx];
    end
    if (wb_load) begin
      wb_addr_q <= {tag_q[wb_idx], {OFF_W{1'b0}}};
      wb_data_q <= line_q[wb_idx];
    end
  end

  assign lookup_ack_o   = (state_q == RESP);
  assign lookup_hit_o   = lookup_ack_o && resp_hit_q;
  assign lookup_line_o  = lookup_hit_o ? resp_line_q : '0;
  assign lookup_dirty_o = lookup_hit_o && resp_dirty_q;
  assign evict_ack_o    = evict_ack_q;
  assign mem_req_o      = (state_q == WB_EVICT) || (state_q == FLUSH_WB);
  assign mem_w_en_o     = mem_req_o;
  assign mem_addr_o     = mem_req_o ? wb_addr_q : '0;
  assign mem_w_data_o   = mem_req_o ? wb_data_q : '0;
  assign flush_done_o   = (state_q == DONE);
  assign occupancy_o    = occ_q;

endmodule

// File: tb/tb_victim_cache_ctrl.sv
module tb_victim_cache_ctrl;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int NE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lookup_req_i = 1'b0;
  logic [AW-1:0] lookup_addr_i = '0;
  logic          lookup_ack_o, lookup_hit_o, lookup_dirty_o;
  logic [LW-1:0] lookup_line_o;
  logic          evict_req_i = 1'b0;
  logic [AW-1:0] evict_addr_i = '0;
  logic [LW-1:0] evict_line_i = '0;
  logic          evict_dirty_i = 1'b0;
  logic          evict_ack_o;
  logic          mem_req_o, mem_w_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_w_data_o;
  logic          mem_ack_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          flush_done_o;
  logic [2:0]    occupancy_o;

  victim_cache_ctrl #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .NUM_ENTRIES(NE), .REPL_MODE(0)
  ) dut (
    .clk(clk), .rst(rst),
    .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
    .lookup_ack_o(lookup_ack_o), .lookup_hit_o(lookup_hit_o),
    .lookup_line_o(lookup_line_o), .lookup_dirty_o(lookup_dirty_o),
    .evict_req_i(evict_req_i), .evict_addr_i(evict_addr_i),
    .evict_line_i(evict_line_i), .evict_dirty_i(evict_dirty_i),
    .evict_ack_o(evict_ack_o),
    .mem_req_o(mem_req_o), .mem_w_en_o(mem_w_en_o), .mem_addr_o(mem_addr_o),
    .mem_w_data_o(mem_w_data_o), .mem_ack_i(mem_ack_i),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_lookup;
    logic [31:0] addr;
    logic [127:0] data;
    logic        dirty;
    logic        exp_hit;
    logic        exp_dirty;
    logic [127:0] exp_line;
    int          exp_occ;
  } vec_t;

  vec_t tv[11];

  localparam logic [127:0] D0 = {4{32'hDEEDBEEF}};

  function automatic logic [127:0] ln(input int k);
    return {4{32'hA000_0000 | k}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    lookup_req_i = 0; evict_req_i = 0; mem_ack_i = 0; flush_i = 0;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic evict_op(input logic [31:0] a, input logic [127:0] d, input logic dty,
                          output int lat, output bit saw_mem);
    evict_req_i = 1; evict_addr_i = a; evict_line_i = d; evict_dirty_i = dty;
    lat = 0; saw_mem = 0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (mem_req_o) saw_mem = 1;
      if (evict_ack_o) begin lat = c; break; end
    end
    evict_req_i = 0;
    tick;
  endtask

  task automatic lookup_op(input logic [31:0] a, output logic hit, output logic [127:0] line,
                           output logic dty, output int lat);
    lookup_req_i = 1; lookup_addr_i = a;
    lat = 0; hit = 0; line = '0; dty = 0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (lookup_ack_o) begin
        lat = c; hit = lookup_hit_o; line = lookup_line_o; dty = lookup_dirty_o;
        break;
      end
    end
    lookup_req_i = 0;
    tick;
  endtask

  task automatic fill4(input logic [3:0] dmask);
    int l; bit m;
    for (int k = 0; k < 4; k++) begin
      evict_op(32'h1000 * (k + 1), ln(k + 1), dmask[k], l, m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat; bit m; logic h; logic [127:0] l; logic d;
    int nwb; bit done; int cyc;

    tv[0]  = '{0, 32'h0001_0010, D0,     0, 0, 0, '0,     1};
    tv[1]  = '{1, 32'h0001_0018, '0,     0, 1, 0, D0,     0};
    tv[2]  = '{0, 32'h0000_1000, ln(1),  0, 0, 0, '0,     1};
    tv[3]  = '{0, 32'h0000_2000, ln(2),  0, 0, 0, '0,     2};
    tv[4]  = '{0, 32'h0000_3000, ln(3),  0, 0, 0, '0,     3};
    tv[5]  = '{0, 32'h0000_4000, ln(4),  0, 0, 0, '0,     4};
    tv[6]  = '{0, 32'h0000_5000, ln(5),  0, 0, 0, '0,     4};
    tv[7]  = '{1, 32'h0000_1000, '0,     0, 0, 0, '0,     4};
    tv[8]  = '{1, 32'h0000_3000, '0,     0, 1, 0, ln(3),  3};
    tv[9]  = '{0, 32'h0000_2000, ln(6),  1, 0, 0, '0,     3};
    tv[10] = '{1, 32'h0000_2008, '0,     0, 1, 1, ln(6),  2};

    // reset state
    #2;
    chk("rst_lookup_ack", lookup_ack_o, 0);
    chk("rst_evict_ack", evict_ack_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_flush_done", flush_done_o, 0);
    chk("rst_occ", occupancy_o, 0);
    do_reset;

    // table-driven transactions
    for (int i = 0; i < 11; i++) begin
      if (tv[i].is_lookup) begin
        lookup_op(tv[i].addr, h, l, d, lat);
        chk($sformatf("v%0d_lat", i), lat, 1);
        chk($sformatf("v%0d_hit", i), h, tv[i].exp_hit);
        chk($sformatf("v%0d_line", i), l, tv[i].exp_line);
        chk($sformatf("v%0d_dirty", i), d, tv[i].exp_dirty);
      end else begin
        evict_op(tv[i].addr, tv[i].data, tv[i].dirty, lat, m);
        chk($sformatf("v%0d_lat", i), lat, 1);
        chk($sformatf("v%0d_no_mem", i), m, 0);
      end
      chk($sformatf("v%0d_occ", i), occupancy_o, tv[i].exp_occ);
    end

    // dirty victim write-back with delayed mem_ack_i
    do_reset;
    fill4(4'b0001);
    evict_req_i = 1; evict_addr_i = 32'h0000_9000; evict_line_i = ln(9); evict_dirty_i = 0;
    tick;
    chk("wb_req", mem_req_o, 1);
    chk("wb_wen", mem_w_en_o, 1);
    chk("wb_addr", mem_addr_o, 32'h0000_1000);
    chk("wb_data", mem_w_data_o, ln(1));
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("wb_hold%0d_req", k), mem_req_o, 1);
      chk($sformatf("wb_hold%0d_addr", k), mem_addr_o, 32'h0000_1000);
      chk($sformatf("wb_hold%0d_ack", k), evict_ack_o, 0);
    end
    chk("wb_hold_data", mem_w_data_o, ln(1));
    mem_ack_i = 1;
    tick;
    mem_ack_i = 0;
    chk("wb_evict_ack", evict_ack_o, 1);
    chk("wb_req_drop", mem_req_o, 0);
    chk("wb_occ", occupancy_o, 4);
    evict_req_i = 0;
    tick;
    lookup_op(32'h0000_9000, h, l, d, lat);
    chk("wb_new_hit", h, 1);
    chk("wb_new_line", l, ln(9));
    lookup_op(32'h0000_1000, h, l, d, lat);
    chk("wb_old_miss", h, 0);

    // simultaneous lookup and evict (swap)
    do_reset;
    evict_op(32'h0000_1010, ln(7), 0, lat, m);
    evict_op(32'h0000_2000, ln(2), 0, lat, m);
    chk("swap_occ0", occupancy_o, 2);
    lookup_req_i = 1; lookup_addr_i = 32'h0000_1010;
    evict_req_i = 1; evict_addr_i = 32'h0001_0010; evict_line_i = D0; evict_dirty_i = 1;
    tick;
    chk("swap_lk_ack", lookup_ack_o, 1);
    chk("swap_lk_hit", lookup_hit_o, 1);
    chk("swap_lk_line", lookup_line_o, ln(7));
    chk("swap_ev_early", evict_ack_o, 0);
    lookup_req_i = 0;
    tick;
    chk("swap_ev_ack", evict_ack_o, 1);
    chk("swap_lk_ack_off", lookup_ack_o, 0);
    chk("swap_occ", occupancy_o, 2);
    evict_req_i = 0;
    tick;
    lookup_op(32'h0001_0010, h, l, d, lat);
    chk("swap_new_line", l, D0);
    chk("swap_new_dirty", d, 1);

    // flush with entries 1 and 3 dirty
    do_reset;
    fill4(4'b1010);
    flush_i = 1;
    tick;
    flush_i = 0;
    nwb = 0; done = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req_o) begin
        if (nwb == 0) begin
          chk("fl_wb0_addr", mem_addr_o, 32'h0000_2000);
          chk("fl_wb0_data", mem_w_data_o, ln(2));
        end else if (nwb == 1) begin
          chk("fl_wb1_addr", mem_addr_o, 32'h0000_4000);
          chk("fl_wb1_data", mem_w_data_o, ln(4));
        end
        nwb++;
        mem_ack_i = 1;
        tick;
        mem_ack_i = 0;
      end else if (flush_done_o) begin
        done = 1;
        break;
      end else begin
        tick;
      end
    end
    chk("fl_done", done, 1);
    chk("fl_nwb", nwb, 2);
    chk("fl_occ", occupancy_o, 0);
    tick;
    chk("fl_done_pulse", flush_done_o, 0);
    lookup_op(32'h0000_4000, h, l, d, lat);
    chk("fl_after_miss", h, 0);

    // clean flush timing: NUM_ENTRIES+1 cycles
    do_reset;
    fill4(4'b0000);
    flush_i = 1;
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      flush_i = 0;
      chk($sformatf("cfl_nomem%0d", c), mem_req_o, 0);
      if (flush_done_o) begin cyc = c; break; end
    end
    chk("cfl_cycles", cyc, NE + 1);
    chk("cfl_occ", occupancy_o, 0);
    tick;

    // reset during write-back
    do_reset;
    fill4(4'b0001);
    evict_req_i = 1; evict_addr_i = 32'h0000_9000; evict_line_i = ln(9); evict_dirty_i = 0;
    tick;
    chk("rwb_req", mem_req_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rwb_req_drop", mem_req_o, 0);
    chk("rwb_wen", mem_w_en_o, 0);
    chk("rwb_addr", mem_addr_o, 0);
    chk("rwb_data", mem_w_data_o, 0);
    chk("rwb_occ", occupancy_o, 0);
    chk("rwb_evict_ack", evict_ack_o, 0);
    evict_req_i = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick;
    lookup_op(32'h0000_1000, h, l, d, lat);
    chk("rwb_lk_ack", lat, 1);
    chk("rwb_lk_miss", h, 0);
    chk("rwb_lk_line", l, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
